// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation-control block.
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        RELEASE = 3'd1,
        RUN     = 3'd2,
        DONE    = 3'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_TRAP    = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_STALL   = 2'd3
    } cause_e;

    localparam logic [7:0] PASS_CODE = 8'd0;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sim_ctrl_popcnt.sv
// Population count of the commit lanes retired in one cycle.
module sim_ctrl_popcnt #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count = count + {{($clog2(W+1)-1){1'b0}}, bits[i]};
        end
    end

endmodule

// File: rtl/sim_ctrl.sv
// Reset sequencing, run counters and sticky verdict for the core harness.
// Optional commit-stall detection is built when SIM_CTRL_STALL_DET_EN is defined.
module sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 2,
    parameter int unsigned RST_HOLD    = 50,
    parameter int unsigned RST_STAGGER = 4,
    parameter int unsigned COMMIT_W    = 2,
    parameter int unsigned TIMEOUT     = 500,
    parameter int unsigned STALL_LIMIT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COMMIT_W-1:0]    commit_valid,
    input  logic                   trap_valid,
    input  logic [7:0]             trap_code,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic [2:0]             state,
    output logic                   run_done,
    output logic                   pass,
    output logic                   fail,
    output logic [1:0]             fail_cause,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instr_cnt
);

    localparam int unsigned SEQ_MAX = max2(RST_HOLD, RST_STAGGER * (NUM_DOMAINS - 1));
    localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int unsigned PC_W    = $clog2(COMMIT_W + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SEQ_W-1:0] REL_LAST = SEQ_W'(RST_STAGGER * (NUM_DOMAINS - 1));

    state_e                 st_q, st_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [NUM_DOMAINS-1:0] dr_q, dr_d;
    logic [CNT_W-1:0]       cyc_q, cyc_d;
    logic [CNT_W-1:0]       ins_q, ins_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    cause_e                 cause_q, cause_d;
    logic [PC_W-1:0]        commit_cnt;
    logic [CNT_W:0]         ins_sum;
    logic                   timeout_hit;
    logic                   stall_hit;

    sim_ctrl_popcnt #(.W(COMMIT_W)) u_popcnt (
        .bits  (commit_valid),
        .count (commit_cnt)
    );

    assign ins_sum     = {1'b0, ins_q} + (CNT_W + 1)'(commit_cnt);
    assign timeout_hit = (TIMEOUT != 0) && (cyc_q == TO_LAST);

`ifdef SIM_CTRL_STALL_DET_EN
    localparam int unsigned STL_W = $clog2(STALL_LIMIT) + 1;

    logic [STL_W-1:0] stall_q;

    assign stall_hit = !(|commit_valid) && (stall_q == STL_W'(STALL_LIMIT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (st_q == RUN) begin
            stall_q <= (|commit_valid) ? '0 : stall_q + 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q    <= HOLD;
            seq_q   <= '0;
            dr_q    <= '1;
            cyc_q   <= '0;
            ins_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            st_q    <= st_d;
            seq_q   <= seq_d;
            dr_q    <= dr_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        seq_d   = seq_q;
        dr_d    = dr_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        cause_d = cause_q;

        unique case (st_q)
            HOLD: begin
                if (seq_q == SEQ_W'(RST_HOLD)) begin
                    // seq restarts as "cycles since RELEASE entry"; domain 0 goes on the entry edge
                    dr_d[0] = 1'b0;
                    seq_d   = SEQ_W'(1);
                    if (RST_STAGGER == 0 || NUM_DOMAINS == 1) begin
                        dr_d = '0;
                        st_d = RUN;
                    end else begin
                        st_d = RELEASE;
                    end
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end
            RELEASE: begin
                for (int unsigned i = 1; i < NUM_DOMAINS; i++) begin
                    if (seq_q == SEQ_W'(RST_STAGGER * i)) begin
                        dr_d[i] = 1'b0;
                    end
                end
                if (seq_q == REL_LAST) begin
                    st_d = RUN;
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end
            RUN: begin
                cyc_d = cyc_q + 1'b1;
                ins_d = ins_sum[CNT_W] ? '1 : ins_sum[CNT_W-1:0];
                if (trap_valid) begin
                    st_d   = DONE;
                    done_d = 1'b1;
                    if (trap_code == PASS_CODE) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d  = 1'b1;
                        cause_d = CAUSE_TRAP;
                    end
                end else if (timeout_hit) begin
                    st_d    = DONE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else if (stall_hit) begin
                    st_d    = DONE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    cause_d = CAUSE_STALL;
                end
            end
            default: ;
        endcase
    end

    assign domain_reset = dr_q;
    assign state        = st_q;
    assign run_done     = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign fail_cause   = cause_q;
    assign cycle_cnt    = cyc_q;
    assign instr_cnt    = ins_q;

endmodule

// File: tb/tb_sim_ctrl.sv
// Directed self-checking bench for sim_ctrl; expectations follow SIM_CTRL_STALL_DET_EN.
module tb_sim_ctrl;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // default-configuration instance
    logic        reset;
    logic [1:0]  commit_valid;
    logic        trap_valid;
    logic [7:0]  trap_code;
    logic [1:0]  domain_reset;
    logic [2:0]  state;
    logic        run_done, pass, fail;
    logic [1:0]  fail_cause;
    logic [31:0] cycle_cnt, instr_cnt;

    // narrow-counter instances, staggered and unstaggered
    logic        s_reset;
    logic [1:0]  s_commit;
    logic        s_trap;
    logic [1:0]  a_dr, b_dr;
    logic [2:0]  a_state, b_state;
    logic        a_done, a_pass, a_fail, b_done, b_pass, b_fail;
    logic [1:0]  a_cause, b_cause;
    logic [3:0]  a_cyc, a_ins, b_cyc, b_ins;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    sim_ctrl #(
        .NUM_DOMAINS(2), .RST_HOLD(50), .RST_STAGGER(4), .COMMIT_W(2),
        .TIMEOUT(500), .STALL_LIMIT(64), .CNT_W(32)
    ) u_dut (
        .clock(clock), .reset(reset), .commit_valid(commit_valid),
        .trap_valid(trap_valid), .trap_code(trap_code),
        .domain_reset(domain_reset), .state(state), .run_done(run_done),
        .pass(pass), .fail(fail), .fail_cause(fail_cause),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    sim_ctrl #(
        .NUM_DOMAINS(2), .RST_HOLD(3), .RST_STAGGER(2), .COMMIT_W(2),
        .TIMEOUT(0), .STALL_LIMIT(64), .CNT_W(4)
    ) u_sat (
        .clock(clock), .reset(s_reset), .commit_valid(s_commit),
        .trap_valid(s_trap), .trap_code(8'd0),
        .domain_reset(a_dr), .state(a_state), .run_done(a_done),
        .pass(a_pass), .fail(a_fail), .fail_cause(a_cause),
        .cycle_cnt(a_cyc), .instr_cnt(a_ins)
    );

    sim_ctrl #(
        .NUM_DOMAINS(2), .RST_HOLD(3), .RST_STAGGER(0), .COMMIT_W(2),
        .TIMEOUT(0), .STALL_LIMIT(64), .CNT_W(4)
    ) u_flat (
        .clock(clock), .reset(s_reset), .commit_valid(s_commit),
        .trap_valid(s_trap), .trap_code(8'd0),
        .domain_reset(b_dr), .state(b_state), .run_done(b_done),
        .pass(b_pass), .fail(b_fail), .fail_cause(b_cause),
        .cycle_cnt(b_cyc), .instr_cnt(b_ins)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".state"}, state, 3'd0);
        check({tag, ".dr"}, domain_reset, 2'b11);
        check({tag, ".cyc"}, cycle_cnt, 0);
        check({tag, ".ins"}, instr_cnt, 0);
        check({tag, ".verdict"}, {run_done, pass, fail, fail_cause}, 5'b0);
    endtask

    // Reset, release at a negedge, and advance to the edge that enters RUN.
    task automatic restart();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(55);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; commit_valid = '0; trap_valid = 1'b0; trap_code = '0;
        s_reset = 1'b0; s_commit = '0; s_trap = 1'b0;

        // reset sequencing with hold and stagger
        tick(10);
        check_reset_vals("rst");
        reset = 1'b1;
        tick(50);
        check("hold49.dr", domain_reset, 2'b11);
        check("hold49.state", state, 3'd0);
        tick(1);
        check("c50.dr", domain_reset, 2'b10);
        check("c50.state", state, 3'd1);
        tick(3);
        check("c53.dr", domain_reset, 2'b10);
        tick(1);
        check("c54.dr", domain_reset, 2'b00);
        check("c54.state", state, 3'd2);
        check("c54.cyc", cycle_cnt, 0);

        // pass trap after 10 double-commit cycles
        commit_valid = 2'b11;
        tick(10);
        check("pre_trap.ins", instr_cnt, 20);
        check("pre_trap.done", run_done, 1'b0);
        commit_valid = 2'b00; trap_valid = 1'b1; trap_code = 8'd0;
        tick(1);
        check("pass.state", state, 3'd3);
        check("pass.verdict", {run_done, pass, fail, fail_cause}, 5'b11000);
        check("pass.ins", instr_cnt, 20);
        check("pass.cyc", cycle_cnt, 11);
        trap_code = 8'd5; commit_valid = 2'b11;
        tick(3);
        check("done_hold.ins", instr_cnt, 20);
        check("done_hold.verdict", {run_done, pass, fail, fail_cause}, 5'b11000);
        trap_valid = 1'b0;

        // async reset out of DONE
        reset = 1'b0;
        #1;
        check_reset_vals("done_rst");

        // trap and commits before RUN are ignored; failing trap on timeout cycle
        tick(2);
        reset = 1'b1; trap_valid = 1'b1; trap_code = 8'd5; commit_valid = 2'b11;
        tick(55);
        check("b_entry.state", state, 3'd2);
        check("b_entry.done", run_done, 1'b0);
        check("b_entry.ins", instr_cnt, 0);
        trap_valid = 1'b0; commit_valid = 2'b01;
        tick(499);
        check("b499.cyc", cycle_cnt, 499);
        check("b499.state", state, 3'd2);
        trap_valid = 1'b1;
        tick(1);
        check("trap5.verdict", {run_done, pass, fail, fail_cause}, 5'b10101);
        check("trap5.cyc", cycle_cnt, 500);
        check("trap5.ins", instr_cnt, 500);
        trap_valid = 1'b0;

        // commit stall: stall verdict with detection, timeout otherwise
        commit_valid = 2'b01;
        restart();
        tick(100);
        check("c100.ins", instr_cnt, 100);
        commit_valid = 2'b00;
`ifdef SIM_CTRL_STALL_DET_EN
        tick(63);
        check("stall63.state", state, 3'd2);
        tick(1);
        check("stall.verdict", {run_done, pass, fail, fail_cause}, 5'b10111);
        check("stall.cyc", cycle_cnt, 164);
`else
        tick(399);
        check("nostall499.state", state, 3'd2);
        tick(1);
        check("nostall.verdict", {run_done, pass, fail, fail_cause}, 5'b10110);
        check("nostall.cyc", cycle_cnt, 500);
`endif
        check("c.ins", instr_cnt, 100);

        // plain timeout with steady commits
        commit_valid = 2'b01;
        restart();
        tick(499);
        check("to499.state", state, 3'd2);
        tick(1);
        check("to.verdict", {run_done, pass, fail, fail_cause}, 5'b10110);
        check("to.cyc", cycle_cnt, 500);
        check("to.ins", instr_cnt, 500);
        commit_valid = 2'b11;
        tick(5);
        check("to_frozen.ins", instr_cnt, 500);
        check("to_frozen.cyc", cycle_cnt, 500);

        // narrow counters: saturation, mid-RUN async reset, zero stagger
        s_reset = 1'b1;
        tick(3);
        check("s_hold.dr", {a_dr, b_dr}, 4'b1111);
        tick(1);
        check("s_c3.a_dr", a_dr, 2'b10);
        check("s_c3.a_state", a_state, 3'd1);
        check("s_c3.b_dr", b_dr, 2'b00);
        check("s_c3.b_state", b_state, 3'd2);
        tick(2);
        check("s_c5.a_dr", a_dr, 2'b00);
        check("s_c5.a_state", a_state, 3'd2);
        check("s_c5.b_cyc", b_cyc, 2);
        s_commit = 2'b11;
        tick(10);
        check("sat.a_ins", a_ins, 15);
        check("sat.a_cyc", a_cyc, 10);
        check("sat.b_ins", b_ins, 15);
        check("sat.b_cyc", b_cyc, 12);
        check("sat.a_done", a_done, 1'b0);
        s_reset = 1'b0;
        #1;
        check("s_rst.state", {a_state, b_state}, 6'd0);
        check("s_rst.dr", {a_dr, b_dr}, 4'b1111);
        check("s_rst.cnt", {a_cyc, a_ins, b_cyc, b_ins}, 16'd0);
        check("s_rst.verdict", {a_done, a_pass, a_fail, a_cause, b_done, b_pass, b_fail, b_cause}, 10'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_ctrl.md
# sim_ctrl

Parametrised simulation-control block for the core harness. It sequences reset release across several design domains with configurable hold and stagger, and counts cycles and retired instructions while the design runs. It ends the run with a sticky pass/fail verdict on a trap, a cycle timeout or, optionally, a commit stall. It sits between the top-level clock/reset source and the design under test, so that run length and reset behaviour are bounded and checked in RTL, not by fixed delays.

## Interface
Parameters:
- NUM_DOMAINS, 2: number of independently released reset domains (≥1).
- RST_HOLD, 50: cycles all domains stay in reset after `reset` deasserts (≥1).
- RST_STAGGER, 4: cycles between successive domain releases (0 = release all domains together).
- COMMIT_W, 2: retire width; number of commit_valid lanes.
- TIMEOUT, 500: maximum RUN cycles; 0 disables the timeout.
- STALL_LIMIT, 64: maximum consecutive RUN cycles with no commit (used only with the stall macro).
- CNT_W, 32: width of both counters.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- commit_valid  in  COMMIT_W  one bit per retired instruction this cycle.
- trap_valid  in  1  end-of-test trap strobe.
- trap_code  in  8  trap code; 0 = pass.
- domain_reset  out  NUM_DOMAINS  active-high reset to each domain.
- state  out  3  current FSM state encoding.
- run_done  out  1  sticky; verdict is valid.
- pass  out  1  sticky pass.
- fail  out  1  sticky fail.
- fail_cause  out  2  0 none, 1 nonzero trap, 2 timeout, 3 stall.
- cycle_cnt  out  CNT_W  RUN cycles elapsed.
- instr_cnt  out  CNT_W  instructions retired in RUN, saturating.

## Operation
- States: HOLD → RELEASE → RUN → DONE. There is no other exit from DONE; only `reset` leaves it.
- While `reset`=0 (asynchronous):
  - state=HOLD.
  - domain_reset all 1.
  - Counters 0.
  - run_done, pass, fail, fail_cause all 0.
- HOLD: a hold counter counts RST_HOLD cycles, then the FSM enters RELEASE.
- RELEASE:
  - Domain i deasserts RST_STAGGER·i cycles after RELEASE entry.
  - Domains release in index order and stay released.
  - The FSM enters RUN on the same edge that releases the last domain.
- RUN:
  - cycle_cnt increments by 1 every cycle.
  - instr_cnt adds popcount(commit_valid) and saturates at all-ones.
  - commit_valid is ignored outside RUN.
- End conditions are evaluated each RUN cycle. Priority when several hold in the same cycle is trap > timeout > stall.
  - trap_valid: go to DONE. pass=1 if trap_code==0; otherwise fail=1 and cause=1.
  - Timeout: TIMEOUT≠0 and cycle_cnt==TIMEOUT-1 → DONE, fail, cause=2.
  - Stall (macro only): stall counter == STALL_LIMIT-1 with no commit this cycle → DONE, fail, cause=3.
- DONE:
  - Counters freeze.
  - The verdict is sticky.
  - domain_reset stays deasserted.
  - trap_valid and commit_valid are ignored.
- trap_valid outside RUN is ignored.
- Asserting `reset` mid-RUN or in DONE immediately re-enters HOLD and clears all state.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Counting from the first rising edge with `reset`=1 as cycle 0, domain i deasserts after cycle RST_HOLD + i·RST_STAGGER.
- run_done, pass/fail and fail_cause update on the clock edge that samples the end condition, so they are visible the next cycle. All of them change together.
- Counts include the terminating cycle's commits, and cycle_cnt includes that cycle. Final cycle_cnt = number of RUN cycles.
- The timeout therefore yields cycle_cnt==TIMEOUT in DONE.

## Configuration
- SIM_CTRL_STALL_DET_EN defined:
  - A stall counter (clog2(STALL_LIMIT)+1 bits) clears on any commit and increments otherwise in RUN.
  - Reaching the limit ends the run with cause 3.
- SIM_CTRL_STALL_DET_EN undefined:
  - No stall counter.
  - cause 3 is never produced.
  - STALL_LIMIT is unused.

## Structure
- Package sim_ctrl_pkg holds:
  - the state enum (HOLD, RELEASE, RUN, DONE);
  - the fail-cause enum;
  - constant PASS_CODE=0.
- Sub-module sim_ctrl_popcnt: parametrised COMMIT_W popcount feeding the saturating instr_cnt adder.
- The top module holds the FSM, hold/stagger counter, run/stall counters and verdict registers.

## Test plan
- Defaults; `reset` low 10 cycles then high → domain_reset[0] falls after cycle 50, domain_reset[1] after cycle 54; state=RUN at that edge; cycle_cnt=0.
- RUN; commit_valid=2'b11 for 10 cycles, then trap_valid with code 0 → instr_cnt=20, pass=1, fail_cause=0, run_done next cycle.
- trap_valid with code 5 in the same cycle cycle_cnt==499 → fail=1, cause=1, not timeout.
- TIMEOUT=500, no trap → DONE, fail, cause=2, cycle_cnt=500; further commits leave instr_cnt unchanged.
- Macro defined, STALL_LIMIT=64, commits stop → fail, cause=3 after 64 idle cycles. Repeat without the macro → run reaches timeout instead.
- Assert `reset` mid-RUN with CNT_W=4 and instr_cnt saturated at 15 → all outputs return to reset values asynchronously; RST_STAGGER=0 rerun releases both domains on the same edge.
